vram_arbiter: RTL and testbench

Shares the single video-memory port (`mem_en`/`mem_we`/`mem_addr`/`mem_din`/`mem_dout`) between three requesters. Port 0 is the video fetch path and gets priority. Ports 1 and 2 (CPU, DMA/init sequencer) share the remaining slots round-robin. The block sits between the requesters and the VRAM/address-decode fabric, accepts one access per cycle, and routes read data back to the issuing port.

---
 rtl/vram_arbiter_if.sv | 42 ++++
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester and memory-side signal bundle for vram_arbiter
//
// Purpose: groups the three-port request/response handshake and the single
//          VRAM port so the arbiter and its environment connect through one bundle.
// Signals:
//   req_valid/req_we [2:0]   per-port request valid / write enable, bit i = port i
//   req_addr  [3*ADDR_W]     port i at [i*ADDR_W +: ADDR_W]
//   req_wdata [3*DATA_W]     port i at [i*DATA_W +: DATA_W]
//   req_ready [2:0]          combinational grant, transfer on valid & ready
//   rsp_valid [2:0]          one-cycle read-data strobe to the issuing port
//   rsp_data                 read data shared by all ports
//   mem_en/mem_we/mem_addr/mem_din   registered memory access
//   mem_dout                 memory read data, one cycle after a read access
// Modports: slave = arbiter view, master = requesters plus memory.

interface vram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [2:0]          req_valid;
   logic [2:0]          req_we;
   logic [3*ADDR_W-1:0] req_addr;
   logic [3*DATA_W-1:0] req_wdata;
   logic [2:0]          req_ready;
   logic [2:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_data;
   logic                mem_en;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_din;
   logic [DATA_W-1:0]   mem_dout;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_dout,
      output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_din
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_dout,
      input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - three-port VRAM arbiter, port 0 priority with starvation guard
//
// Purpose: shares one video-memory port between the video fetch path (port 0,
//          priority) and two round-robin requesters (ports 1 and 2). One access
//          is accepted per cycle, issued to memory the next cycle, and read data
//          is steered back to the issuing port two cycles after acceptance.
// Ports:
//   i_clk    sole clock
//   i_rst    synchronous active-high reset
//   io_bus   vram_arbiter_if.slave: request/response handshake and memory port

module vram_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   vram_arbiter_if.slave   io_bus
);

   localparam int              HC_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

   logic [HC_W-1:0]   r_hold_cnt;
   logic              r_rr_last2;     // 1: port 2 held the last RR slot
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_din;
   logic              r_s1_rd;        // owner pipeline stage 1: aligned with mem_en
   logic [1:0]        r_s1_port;
   logic              r_s2_rd;        // owner pipeline stage 2: aligned with mem_dout
   logic [1:0]        r_s2_port;
   logic [DATA_W-1:0] r_rsp_data;

   logic              w_rr_pend;
   logic              w_pick1;
   logic              w_pick2;
   logic              w_p0_win;
   logic [2:0]        w_grant;
   logic              w_fire;
   logic [1:0]        w_port;
   logic              w_we_sel;
   logic [ADDR_W-1:0] w_addr_sel;
   logic [DATA_W-1:0] w_wdata_sel;
   logic [2:0]        w_rsp_valid;
   logic [DATA_W-1:0] w_rsp_data;

   always_comb begin
      w_rr_pend = io_bus.req_valid[1] | io_bus.req_valid[2];
      // Contested RR slot goes to the port that did not go last.
      w_pick1   = io_bus.req_valid[1] & (r_rr_last2 | ~io_bus.req_valid[2]);
      w_pick2   = io_bus.req_valid[2] & (~r_rr_last2 | ~io_bus.req_valid[1]);
      // Port 0 yields only once it has used up its hold budget against a waiting RR port.
      w_p0_win  = io_bus.req_valid[0] & ~((r_hold_cnt == HOLD_MAX) & w_rr_pend);

      w_grant = 3'b000;
      if (!i_rst) begin
         w_grant = {~w_p0_win & w_pick2, ~w_p0_win & w_pick1, w_p0_win};
      end
      w_fire = |w_grant;

      w_port      = 2'd0;
      w_we_sel    = io_bus.req_we[0];
      w_addr_sel  = io_bus.req_addr[0 +: ADDR_W];
      w_wdata_sel = io_bus.req_wdata[0 +: DATA_W];
      if (w_grant[1]) begin
         w_port      = 2'd1;
         w_we_sel    = io_bus.req_we[1];
         w_addr_sel  = io_bus.req_addr[ADDR_W +: ADDR_W];
         w_wdata_sel = io_bus.req_wdata[DATA_W +: DATA_W];
      end else if (w_grant[2]) begin
         w_port      = 2'd2;
         w_we_sel    = io_bus.req_we[2];
         w_addr_sel  = io_bus.req_addr[2*ADDR_W +: ADDR_W];
         w_wdata_sel = io_bus.req_wdata[2*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_cnt <= '0;
         r_rr_last2 <= 1'b1;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_s1_rd    <= 1'b0;
         r_s1_port  <= 2'd0;
         r_s2_rd    <= 1'b0;
         r_s2_port  <= 2'd0;
         r_rsp_data <= '0;
      end else begin
         if (w_grant[1] | w_grant[2]) begin
            r_hold_cnt <= '0;
            r_rr_last2 <= w_grant[2];
         end else if (!w_rr_pend) begin
            r_hold_cnt <= '0;
         end else if (w_grant[0] && (r_hold_cnt != HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end

         r_mem_en   <= w_fire;
         r_mem_we   <= w_fire & w_we_sel;
         r_mem_addr <= w_fire ? w_addr_sel  : '0;
         r_mem_din  <= w_fire ? w_wdata_sel : '0;

         r_s1_rd    <= w_fire & ~w_we_sel;
         r_s1_port  <= w_port;
         r_s2_rd    <= r_s1_rd;
         r_s2_port  <= r_s1_port;

         if (r_s2_rd) begin
            r_rsp_data <= io_bus.mem_dout;
         end
      end
   end

   // Response data passes mem_dout straight through in its valid cycle and
   // otherwise holds the last delivered word.
   always_comb begin
      w_rsp_valid = 3'b000;
      w_rsp_data  = r_rsp_data;
      if (r_s2_rd) begin
         w_rsp_valid = 3'b001 << r_s2_port;
         w_rsp_data  = io_bus.mem_dout;
      end
   end

   assign io_bus.req_ready = w_grant;
   assign io_bus.rsp_valid = w_rsp_valid;
   assign io_bus.rsp_data  = w_rsp_data;
   assign io_bus.mem_en    = r_mem_en;
   assign io_bus.mem_we    = r_mem_we;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.mem_din   = r_mem_din;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter

module tb_vram_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous VRAM: unwritten words read back as the low address half.
   logic [31:0] env_mem [logic [31:0]];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_din;
         else bus.mem_dout <= env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr]
                                                            : {16'h0, bus.mem_addr[15:0]};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          cyc;
      int          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        q[$];
   logic [31:0] ref_mem [logic [31:0]];
   int          m_hold = 0;
   int          m_last = 2;
   logic [31:0] m_rsp_data = 32'h0;
   int          cyc = 0;

   task automatic model_step();
      logic [2:0]  v;
      int          g;
      int          rr;
      bit          pend;
      logic [2:0]  e_ready;
      logic        e_en, e_we;
      logic [31:0] e_addr, e_din;
      logic [2:0]  e_rv;
      txn_t        t;
      txn_t        keep[$];

      v    = bus.req_valid;
      pend = v[1] || v[2];
      rr   = -1;
      if (v[1] && v[2]) rr = (m_last == 2) ? 1 : 2;
      else if (v[1])    rr = 1;
      else if (v[2])    rr = 2;
      g = -1;
      if (!rst) begin
         if (v[0] && !(m_hold == MH && pend)) g = 0;
         else g = rr;
      end
      e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;

      e_en = 0; e_we = 0; e_addr = 0; e_din = 0; e_rv = 0;
      foreach (q[i]) begin
         if (q[i].cyc == cyc - 1) begin
            e_en = 1; e_we = q[i].we; e_addr = q[i].addr;
            e_din = q[i].we ? q[i].data : 32'h0;
         end
         if (q[i].cyc == cyc - 2 && !q[i].we) begin
            e_rv = 3'(1 << q[i].port);
            m_rsp_data = q[i].data;
         end
      end

      chk("req_ready", {29'h0, bus.req_ready}, {29'h0, e_ready});
      chk("mem_en",    {31'h0, bus.mem_en},    {31'h0, e_en});
      chk("mem_we",    {31'h0, bus.mem_we},    {31'h0, e_we});
      chk("mem_addr",  bus.mem_addr,           e_addr);
      chk("mem_din",   bus.mem_din,            e_din);
      chk("rsp_valid", {29'h0, bus.rsp_valid}, {29'h0, e_rv});
      chk("rsp_data",  bus.rsp_data,           m_rsp_data);
      chk("hold_cnt",  32'(dut.r_hold_cnt),    32'(m_hold));

      if (rst) begin
         q.delete();
         m_hold = 0;
         m_last = 2;
         m_rsp_data = 32'h0;
      end else begin
         if (g >= 0) begin
            t.cyc  = cyc;
            t.port = g;
            t.we   = bus.req_we[g];
            t.addr = bus.req_addr[g*AW +: AW];
            if (t.we) begin
               t.data = bus.req_wdata[g*DW +: DW];
               ref_mem[t.addr] = t.data;
            end else begin
               t.data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : {16'h0, t.addr[15:0]};
            end
            q.push_back(t);
         end
         if (g == 1 || g == 2) begin
            m_last = g;
            m_hold = 0;
         end else if (!pend) begin
            m_hold = 0;
         end else if (g == 0 && m_hold < MH) begin
            m_hold = m_hold + 1;
         end
         foreach (q[i]) if (q[i].cyc >= cyc - 1) keep.push_back(q[i]);
         q = keep;
      end
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         model_step();
         cyc++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input bit v, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
      bus.req_valid[p]          = v;
      bus.req_we[p]             = we;
      bus.req_addr[p*AW +: AW]  = a;
      bus.req_wdata[p*DW +: DW] = d;
   endtask

   logic [2:0] gr [0:17];
   logic [2:0] rr_exp [0:5] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};

   initial begin
      bus.req_valid = 3'b000;
      bus.req_we    = 3'b000;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      set_port(0, 1, 0, 32'h10, 0);
      set_port(1, 1, 0, 32'h20, 0);
      set_port(2, 1, 0, 32'h30, 0);

      // Reset held with every port requesting.
      repeat (3) begin
         @(negedge clk);
         chk("rst_ready",     {29'h0, bus.req_ready}, 32'h0);
         chk("rst_mem_en",    {31'h0, bus.mem_en},    32'h0);
         chk("rst_mem_addr",  bus.mem_addr,           32'h0);
         chk("rst_rsp_valid", {29'h0, bus.rsp_valid}, 32'h0);
         chk("rst_rsp_data",  bus.rsp_data,           32'h0);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("release_ready", {29'h0, bus.req_ready}, 32'h1);
      tick();
      bus.req_valid = 3'b000;
      repeat (3) tick();

      // Single read on port 1.
      set_port(1, 1, 0, 32'h0610_0005, 0);
      @(negedge clk);
      chk("rd_ready", {29'h0, bus.req_ready}, 32'h2);
      tick();
      bus.req_valid = 3'b000;
      @(negedge clk);
      chk("rd_mem_en",   {31'h0, bus.mem_en}, 32'h1);
      chk("rd_mem_we",   {31'h0, bus.mem_we}, 32'h0);
      chk("rd_mem_addr", bus.mem_addr, 32'h0610_0005);
      tick();
      @(negedge clk);
      chk("rd_rsp_valid", {29'h0, bus.rsp_valid}, 32'h2);
      chk("rd_rsp_data",  bus.rsp_data, 32'h0000_0005);
      tick();
      @(negedge clk);
      chk("rd_rsp_idle", {29'h0, bus.rsp_valid}, 32'h0);
      chk("rd_rsp_hold", bus.rsp_data, 32'h0000_0005);

      // Round-robin between ports 1 and 2; port 1 went last so port 2 leads.
      tick();
      set_port(1, 1, 0, 32'h100, 0);
      set_port(2, 1, 0, 32'h200, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("rr_grant%0d", i), {29'h0, bus.req_ready}, {29'h0, rr_exp[i]});
         tick();
      end
      bus.req_valid = 3'b000;
      repeat (3) tick();

      // Starvation guard: 8 port-0 grants then one port-1 grant, repeating.
      set_port(0, 1, 0, 32'h10, 0);
      set_port(1, 1, 0, 32'h110, 0);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         gr[i] = bus.req_ready;
         chk($sformatf("starve_grant%0d", i), {29'h0, gr[i]},
             (i % 9 == 8) ? 32'h2 : 32'h1);
         if (i > 0 && gr[i-1] == 3'b010)
            chk("starve_hold_clear", 32'(dut.r_hold_cnt), 32'h0);
         tick();
      end
      bus.req_valid = 3'b000;
      repeat (2) tick();

      // Write then immediate read of the same address on port 0.
      set_port(0, 1, 1, 32'h0630_0000, 32'hFF00_00FF);
      @(negedge clk);
      chk("pipe_wr_ready", {29'h0, bus.req_ready}, 32'h1);
      tick();
      set_port(0, 1, 0, 32'h0630_0000, 0);
      @(negedge clk);
      chk("pipe_rd_ready", {29'h0, bus.req_ready}, 32'h1);
      chk("pipe_wr_en",    {31'h0, bus.mem_en}, 32'h1);
      chk("pipe_wr_we",    {31'h0, bus.mem_we}, 32'h1);
      chk("pipe_wr_din",   bus.mem_din, 32'hFF00_00FF);
      tick();
      bus.req_valid = 3'b000;
      @(negedge clk);
      chk("pipe_rd_en",   {31'h0, bus.mem_en}, 32'h1);
      chk("pipe_rd_we",   {31'h0, bus.mem_we}, 32'h0);
      chk("pipe_rd_addr", bus.mem_addr, 32'h0630_0000);
      tick();
      @(negedge clk);
      chk("pipe_rsp_valid", {29'h0, bus.rsp_valid}, 32'h1);
      chk("pipe_rsp_data",  bus.rsp_data, 32'hFF00_00FF);

      // Reset the cycle after a port-2 read is accepted.
      tick();
      set_port(2, 1, 0, 32'h0620_0002, 0);
      @(negedge clk);
      chk("mid_ready", {29'h0, bus.req_ready}, 32'h4);
      tick();
      bus.req_valid = 3'b000;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_issue_en", {31'h0, bus.mem_en}, 32'h1);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("mid_no_rsp%0d", k), {29'h0, bus.rsp_valid}, 32'h0);
         tick();
      end
      set_port(1, 1, 0, 32'h0610_0001, 0);
      set_port(2, 1, 0, 32'h0620_0003, 0);
      @(negedge clk);
      chk("mid_rr_after_rst", {29'h0, bus.req_ready}, 32'h2);
      tick();
      bus.req_valid = 3'b000;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
